instruction_fetch: RTL and testbench
====================================

Name: instruction_fetch

Overview:
Fetch stage of the stack processor, sitting directly upstream of the execute/stack core inside top. It divides CLK down to an instruction tick using the INSTRUCTION_CLOCK_BIT scheme, reads one instruction per tick from a synchronous program ROM at PC, and hands it downstream over a valid/ready handshake. It applies PC increment or a jump on each accepted instruction.

Parameters:
INSTRUCTION_CLOCK_BIT, 22, divider bit; one tick every 2^(INSTRUCTION_CLOCK_BIT+1) CLK cycles (benches use 2, giving one tick per 8 cycles)
ADDR_WIDTH, 8, PC / ROM address width
INSTR_WIDTH, 8, instruction word width

Ports:
CLK  in  1  system clock, rising edge
RST_N  in  1  asynchronous active-low reset
ROM_ADDR  out  ADDR_WIDTH  ROM address, continuously equal to PC
ROM_DATA  in  INSTR_WIDTH  ROM read data, valid one cycle after ROM_ADDR is sampled
INSTR  out  INSTR_WIDTH  fetched instruction to execute stage
INSTR_VALID  out  1  INSTR holds a valid instruction
INSTR_READY  in  1  execute stage accepts INSTR
JUMP  in  1  on handshake: load PC from JUMP_ADDR instead of incrementing
JUMP_ADDR  in  ADDR_WIDTH  jump target
HALT  in  1  suppress new fetches
PC  out  ADDR_WIDTH  current program counter
TICK  out  1  one-cycle instruction tick pulse
OVERRUN  out  1  sticky: a tick was dropped

Behaviour:
- Reset (RST_N low, async): divider=0, PC=0, INSTR=0, INSTR_VALID=0, pending=0, OVERRUN=0, state IDLE. TICK=0 while the divider is 0. ROM_ADDR=0.
- Divider: (INSTRUCTION_CLOCK_BIT+1)-bit free-running up-counter that wraps.
  - TICK is combinational: high when counter == 2^INSTRUCTION_CLOCK_BIT.
  - With BIT=2, the first TICK occurs in the cycle after the 4th rising edge following reset release, then every 8 cycles.
- FSM states IDLE, FETCH, WAIT, VALID. Let T be the cycle in which IDLE sees (TICK or pending) and HALT=0.
  - IDLE -> FETCH: at the end of T. pending is cleared.
  - FETCH (T+1): ROM samples ROM_ADDR=PC -> WAIT.
  - WAIT (T+2): ROM_DATA valid; INSTR<=ROM_DATA, INSTR_VALID<=1 -> VALID.
  - VALID (T+3 onward): INSTR and INSTR_VALID held stable while INSTR_READY=0.
  - Handshake (VALID and INSTR_READY=1): next cycle INSTR_VALID=0 and state IDLE. PC<=JUMP ? JUMP_ADDR : PC+1, with wrap mod 2^ADDR_WIDTH. INSTR keeps its last value.
  - Minimum tick-to-valid latency: 3 cycles.
- Tick outside IDLE (or in IDLE with HALT=1 handled below):
  - Tick while state != IDLE: set pending.
  - Tick while pending is already 1: drop it and set OVERRUN=1 (sticky until reset).
  - IDLE with pending=1 and HALT=0: fetch starts immediately. With READY held high, the next fetch begins the cycle after the handshake.
- HALT:
  - Only blocks the IDLE->FETCH transition.
  - While HALT=1 in IDLE, ticks are ignored and pending is cleared.
  - An in-flight fetch or held instruction completes normally.
  - After HALT falls, fetching resumes at the next TICK.
- Simultaneous events:
  - Tick in the same cycle as a handshake sets pending; the fetch starts from the IDLE cycle that follows.
  - JUMP/JUMP_ADDR are sampled only on the handshake cycle and ignored otherwise.
- Reset mid-operation in any state returns all outputs to their reset values immediately; no partial instruction is presented.

Test Plan:
1. BIT=2, ROM[n]=n+0x10, READY=1 -> INSTR_VALID pulses 1 cycle every 8 cycles, each 3 cycles after TICK. INSTR sequence 0x10, 0x11, 0x12; PC 0 -> 1 -> 2; OVERRUN=0.
2. READY=0 for 20 cycles after first valid -> INSTR=0x10 and VALID=1 held stable, PC=0. Second tick sets pending; third tick sets OVERRUN=1. When READY=1, the next fetch starts immediately and INSTR=0x11 appears 4 cycles after the handshake.
3. JUMP=1, JUMP_ADDR=0x40 on the handshake of INSTR=0x12 -> PC=0x40 and next INSTR=0x50. JUMP=1 pulsed outside a handshake -> no effect.
4. ADDR_WIDTH=4 with PC run to 15 -> after the handshake PC=0, ROM_ADDR=0, and next INSTR=ROM[0].
5. HALT=1 asserted while in VALID -> the current instruction still handshakes; no further VALID for 3 ticks; pending=0, OVERRUN unchanged. HALT=0 -> the next fetch follows the next TICK.
6. RST_N pulsed low during WAIT -> INSTR_VALID=0, PC=0, INSTR=0, OVERRUN=0 asynchronously. After release, the first TICK reappears after 4 edges and INSTR=0x10 follows.

Source files
------------

// File: rtl/instruction_fetch.sv
// instruction_fetch: fetch stage of the stack processor.
// Divides CLK down to an instruction tick, reads one ROM word per tick at PC
// and presents it to the execute stage over INSTR_VALID/INSTR_READY.
// Ports:
//   CLK, RST_N            clock (rising edge), asynchronous active-low reset
//   ROM_ADDR / ROM_DATA   synchronous ROM interface (data one cycle after address)
//   INSTR, INSTR_VALID    fetched word and its valid flag, held until INSTR_READY
//   INSTR_READY           execute stage accepts INSTR
//   JUMP, JUMP_ADDR       on handshake, load PC from JUMP_ADDR instead of PC+1
//   HALT                  blocks starting new fetches
//   PC, TICK, OVERRUN     program counter, tick pulse, sticky dropped-tick flag
module instruction_fetch #(
  parameter int INSTRUCTION_CLOCK_BIT = 22,
  parameter int ADDR_WIDTH            = 8,
  parameter int INSTR_WIDTH           = 8
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  output logic [ADDR_WIDTH-1:0]  ROM_ADDR,
  input  logic [INSTR_WIDTH-1:0] ROM_DATA,
  output logic [INSTR_WIDTH-1:0] INSTR,
  output logic                   INSTR_VALID,
  input  logic                   INSTR_READY,
  input  logic                   JUMP,
  input  logic [ADDR_WIDTH-1:0]  JUMP_ADDR,
  input  logic                   HALT,
  output logic [ADDR_WIDTH-1:0]  PC,
  output logic                   TICK,
  output logic                   OVERRUN
);

  localparam int DIV_W = INSTRUCTION_CLOCK_BIT + 1;
  // Tick fires when only the top divider bit is set, so never while the
  // divider sits at zero after reset.
  localparam logic [DIV_W-1:0] TICK_VAL = DIV_W'(1) << INSTRUCTION_CLOCK_BIT;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WAIT  = 2'd2,
    ST_VALID = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [DIV_W-1:0]       div_q, div_d;
  logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic                   valid_q, valid_d;
  logic                   pending_q, pending_d;
  logic                   overrun_q, overrun_d;
  logic                   tick;

  assign tick  = (div_q == TICK_VAL);
  assign div_d = div_q + DIV_W'(1);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    valid_d   = valid_q;
    pending_d = pending_q;
    overrun_d = overrun_q;

    case (state_q)
      ST_IDLE: begin
        if (HALT) begin
          // Halted: ticks are discarded and any queued tick is forgotten.
          pending_d = 1'b0;
        end else if (tick || pending_q) begin
          state_d   = ST_FETCH;
          pending_d = 1'b0;
        end
      end
      // ROM samples ROM_ADDR at the end of this cycle.
      ST_FETCH: state_d = ST_WAIT;
      ST_WAIT: begin
        instr_d = ROM_DATA;
        valid_d = 1'b1;
        state_d = ST_VALID;
      end
      ST_VALID: begin
        if (INSTR_READY) begin
          valid_d = 1'b0;
          pc_d    = JUMP ? JUMP_ADDR : pc_q + ADDR_WIDTH'(1);
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Busy when a tick arrives: queue one tick, drop any further ones.
    if (state_q != ST_IDLE && tick) begin
      if (pending_q) overrun_d = 1'b1;
      else           pending_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= ST_IDLE;
      div_q     <= '0;
      pc_q      <= '0;
      instr_q   <= '0;
      valid_q   <= 1'b0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      valid_q   <= valid_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

  assign ROM_ADDR    = pc_q;
  assign PC          = pc_q;
  assign INSTR       = instr_q;
  assign INSTR_VALID = valid_q;
  assign TICK        = tick;
  assign OVERRUN     = overrun_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Testbench for instruction_fetch: randomized and directed stimulus checked
// against a deadline-based reference model and an instruction scoreboard.
module tb_instruction_fetch;

  localparam int BIT    = 2;
  localparam int AW     = 8;
  localparam int IW     = 8;
  localparam int PERIOD = 1 << (BIT + 1);
  localparam int TPHASE = 1 << BIT;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic [AW-1:0] ROM_ADDR;
  logic [IW-1:0] ROM_DATA;
  logic [IW-1:0] INSTR;
  logic          INSTR_VALID;
  logic          INSTR_READY = 1'b1;
  logic          JUMP = 1'b0;
  logic [AW-1:0] JUMP_ADDR = '0;
  logic          HALT = 1'b0;
  logic [AW-1:0] PC;
  logic          TICK;
  logic          OVERRUN;

  always #5 CLK = ~CLK;

  instruction_fetch #(
    .INSTRUCTION_CLOCK_BIT(BIT),
    .ADDR_WIDTH(AW),
    .INSTR_WIDTH(IW)
  ) dut (
    .CLK(CLK), .RST_N(RST_N),
    .ROM_ADDR(ROM_ADDR), .ROM_DATA(ROM_DATA),
    .INSTR(INSTR), .INSTR_VALID(INSTR_VALID), .INSTR_READY(INSTR_READY),
    .JUMP(JUMP), .JUMP_ADDR(JUMP_ADDR), .HALT(HALT),
    .PC(PC), .TICK(TICK), .OVERRUN(OVERRUN)
  );

  // Synchronous program ROM: ROM[n] = n + 0x10.
  logic [IW-1:0] rom [256];
  always @(posedge CLK) ROM_DATA <= rom[ROM_ADDR];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A fetch started in cycle c shows its word from cycle c+3 until accepted.
  typedef struct { logic [IW-1:0] val; time t; } exp_t;
  exp_t sbq[$];

  int            m_cyc = 0;
  int            m_valid_at = 0;
  bit            m_busy = 0, m_pending = 0, m_overrun = 0;
  logic [AW-1:0] m_pc = '0;
  logic [IW-1:0] m_fetch_val = '0, m_last = '0;

  always @(negedge CLK) begin : model
    bit m_tick, m_vnow;
    if (!RST_N) begin
      chk("rst_valid", INSTR_VALID, 0);
      chk("rst_pc", PC, 0);
      chk("rst_rom_addr", ROM_ADDR, 0);
      chk("rst_instr", INSTR, 0);
      chk("rst_overrun", OVERRUN, 0);
      chk("rst_tick", TICK, 0);
      m_cyc = 0; m_busy = 0; m_pending = 0; m_overrun = 0;
      m_pc = '0; m_last = '0; m_fetch_val = '0;
      sbq.delete();
    end else begin
      m_tick = (m_cyc % PERIOD) == TPHASE;
      m_vnow = m_busy && (m_cyc >= m_valid_at);
      chk("tick", TICK, m_tick);
      chk("pc", PC, m_pc);
      chk("rom_addr", ROM_ADDR, m_pc);
      chk("valid", INSTR_VALID, m_vnow);
      chk("instr", INSTR, m_vnow ? m_fetch_val : m_last);
      chk("overrun", OVERRUN, m_overrun);
      if (m_busy) begin
        if (m_tick) begin
          if (m_pending) m_overrun = 1;
          else           m_pending = 1;
        end
        if (m_vnow && INSTR_READY) begin
          m_busy = 0;
          m_last = m_fetch_val;
          m_pc   = JUMP ? JUMP_ADDR : m_pc + 8'd1;
        end
      end else if (HALT) begin
        m_pending = 0;
      end else if (m_tick || m_pending) begin
        m_busy      = 1;
        m_pending   = 0;
        m_valid_at  = m_cyc + 3;
        m_fetch_val = rom[m_pc];
        sbq.push_back('{rom[m_pc], $time + 30});
      end
      m_cyc++;
    end
  end

  // ---------------- scoreboard monitor ----------------
  bit prev_vld = 0;
  always @(negedge CLK) begin : monitor
    exp_t e;
    if (RST_N && INSTR_VALID && !prev_vld) begin
      if (sbq.size() == 0) begin
        chk("sb_unexpected_valid", 32'(INSTR_VALID), 0);
      end else begin
        e = sbq.pop_front();
        chk("sb_instr", INSTR, e.val);
        chk("sb_latency", 32'($time), 32'(e.t));
      end
    end
    prev_vld = RST_N && INSTR_VALID;
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic wait_valid(input int budget);
    int k = 0;
    while (!INSTR_VALID && k < budget) begin cyc(1); k++; end
    if (k >= budget) chk("wait_valid_timeout", 0, 1);
  endtask

  // Hold JUMP until exactly one handshake has taken it.
  task automatic do_jump(input logic [AW-1:0] addr);
    JUMP_ADDR   = addr;
    JUMP        = 1'b1;
    INSTR_READY = 1'b1;
    wait_valid(40);
    cyc(1);
    JUMP = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = IW'(i + 16);
    cyc(3);
    RST_N = 1'b1;

    // Free running with READY high: 0x10, 0x11, 0x12 ...
    cyc(30);

    // Stall the consumer so pending and then OVERRUN get set.
    INSTR_READY = 1'b0;
    cyc(40);
    INSTR_READY = 1'b1;
    cyc(20);

    // Jump to 0x40, then JUMP pulses outside handshakes.
    do_jump(8'h40);
    cyc(20);
    for (int i = 0; i < 40; i++) begin
      JUMP      = !INSTR_VALID && ($urandom_range(1) == 1);
      JUMP_ADDR = AW'($urandom);
      cyc(1);
    end
    JUMP = 1'b0;

    // PC wrap: 0xFF -> 0x00.
    do_jump(8'hFF);
    cyc(20);

    // HALT raised while an instruction is held.
    INSTR_READY = 1'b0;
    wait_valid(40);
    HALT = 1'b1;
    cyc(2);
    INSTR_READY = 1'b1;
    cyc(30);
    HALT = 1'b0;
    cyc(20);

    // Reset in the middle of a fetch (WAIT is two cycles after the tick).
    begin
      int k = 0;
      while (!TICK && k < 20) begin cyc(1); k++; end
      if (k >= 20) chk("wait_tick_timeout", 0, 1);
    end
    cyc(2);
    RST_N = 1'b0;
    cyc(3);
    RST_N = 1'b1;
    cyc(30);

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      INSTR_READY = ($urandom_range(2) != 0);
      HALT        = ($urandom_range(9) == 0);
      JUMP        = ($urandom_range(3) == 0);
      JUMP_ADDR   = AW'($urandom);
      if (i == 400) RST_N = 1'b0;
      if (i == 402) RST_N = 1'b1;
      cyc(1);
    end
    HALT = 1'b0;
    INSTR_READY = 1'b1;
    JUMP = 1'b0;
    cyc(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
